bennett_square_clkgen: RTL and testbench

- Digital square-wave Bennett-clock generator for the adiabatic MIPS processor.
- Produces WIDTH staggered phase clocks. The phases rise one per clock, in ascending order, and then fall one per clock in reverse order, giving the nested "Bennett" envelope.
- Also produces Mclk, a plateau marker used to derive the SRAM strobe, and instFlag, an instruction-boundary pulse used as the processor's Fclk.
- Sits at top level beside the processor pad-ring; the processor consumes phases 1..WIDTH-1.

---
 rtl/bennett_square_clkgen.sv | 61 ++++++
 tb/tb_bennett_square_clkgen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bennett_square_clkgen.sv
// Bennett-clock generator for the adiabatic MIPS core.
// A step counter sweeps 0..2*WIDTH; the phase clocks rise one per clk in
// ascending order, hold for a two-clk plateau, then fall in reverse order,
// giving the nested Bennett envelope. Step 0 is the idle slot between cycles.
// Every output is a flop decoded from the counter's next value, so outputs
// change on the same edge as the counter and never glitch.
//
// Handshake: none. The block free-runs whenever reset is low; consumers
// sample clkp/Mclk/instFlag as plain registered levels.
module bennett_square_clkgen #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  output logic [0:WIDTH-1] clkp,
  output logic             Mclk,
  output logic             instFlag
);

  localparam int LAST = 2 * WIDTH;
  localparam int SW   = $clog2(2 * WIDTH + 1);

  logic [SW-1:0]    r_s;
  logic [SW-1:0]    w_s_next;
  int               w_s_int;
  logic [0:WIDTH-1] w_clkp_next;
  logic             w_mclk_next;
  logic             w_inst_next;

  // Next step value: count up, wrap from the last falling step to idle.
  always_comb begin
    w_s_next = (r_s == SW'(LAST)) ? '0 : r_s + SW'(1);
    w_s_int  = 32'(w_s_next);
  end

  // Decode the next step into phase, plateau and idle-slot levels.
  always_comb begin
    w_clkp_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_clkp_next[i] = (w_s_int >= i + 1) && (w_s_int <= LAST - i);
    end
    w_mclk_next = (w_s_int == WIDTH) || (w_s_int == WIDTH + 1);
    w_inst_next = (w_s_int == 0);
  end

  // Register the counter and all decoded outputs; reset forces everything low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s      <= '0;
      clkp     <= '0;
      Mclk     <= 1'b0;
      instFlag <= 1'b0;
    end else begin
      r_s      <= w_s_next;
      clkp     <= w_clkp_next;
      Mclk     <= w_mclk_next;
      instFlag <= w_inst_next;
    end
  end

endmodule

// File: tb/tb_bennett_square_clkgen.sv
// Bench for bennett_square_clkgen: a WIDTH=11 and a WIDTH=3 instance share
// clock and reset. A reference model counts edges since reset release and
// derives each expected output word arithmetically; directed checks cover
// the rising/falling order, plateau, mid-cycle reset and periodicity.
module tb_bennett_square_clkgen;

  localparam int W_A = 11;
  localparam int W_B = 3;

  logic            clk;
  logic            reset;
  logic [0:W_A-1]  clkp_a;
  logic            mclk_a;
  logic            inst_a;
  logic [0:W_B-1]  clkp_b;
  logic            mclk_b;
  logic            inst_b;

  int n_checks;
  int n_pass;

  bennett_square_clkgen #(.WIDTH(W_A)) u_dut_a (
    .clk(clk), .reset(reset), .clkp(clkp_a), .Mclk(mclk_a), .instFlag(inst_a)
  );

  bennett_square_clkgen #(.WIDTH(W_B)) u_dut_b (
    .clk(clk), .reset(reset), .clkp(clkp_b), .Mclk(mclk_b), .instFlag(inst_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Expected {phases, Mclk, instFlag} for width w, n edges after release.
  // Phases are packed with clkp[0] as the most significant phase bit.
  function automatic logic [12:0] exp_word(input int w, input int n, input bit rst_edge);
    int s;
    logic [10:0] ph;
    logic mc, fl;
    ph = '0;
    s  = rst_edge ? 0 : (n % (2 * w + 1));
    for (int i = 0; i < w; i++) ph[w-1-i] = (s >= i + 1) && (s <= 2 * w - i);
    mc = (s == w) || (s == w + 1);
    fl = !rst_edge && (s == 0);
    return {ph, mc, fl};
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [25:0] exp_q[$];
  int  m_n;
  bit  m_rst;
  bit  m_valid;

  // Model: on every edge, compute what each instance should show afterwards.
  always @(posedge clk) begin
    if (reset) begin
      m_n   = 0;
      m_rst = 1'b1;
    end else begin
      m_n   = m_n + 1;
      m_rst = 1'b0;
    end
    if (reset || m_valid) begin
      m_valid = 1'b1;
      exp_q.push_back({exp_word(W_A, m_n, m_rst), exp_word(W_B, m_n, m_rst)});
    end
  end

  int cyc_a, last_a, mcnt_a;
  int cyc_b, last_b;

  // Monitor: compare against the model and check invariants/periodicity.
  always @(negedge clk) begin
    logic [25:0] e;
    bit nest_a, nest_b;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("word_w11", {51'd0, clkp_a, mclk_a, inst_a}, {51'd0, e[25:13]});
      check("word_w3", {59'd0, clkp_b, mclk_b, inst_b}, {51'd0, e[12:0]});
      nest_a = 1'b1;
      for (int j = 1; j < W_A; j++) if (clkp_a[j] && !clkp_a[j-1]) nest_a = 1'b0;
      nest_b = 1'b1;
      for (int j = 1; j < W_B; j++) if (clkp_b[j] && !clkp_b[j-1]) nest_b = 1'b0;
      check("nest_w11", 64'(nest_a), 64'd1);
      check("nest_w3", 64'(nest_b), 64'd1);
      check("mclk_inner_w11", 64'(mclk_a), 64'(clkp_a[W_A-1]));
      check("mclk_inner_w3", 64'(mclk_b), 64'(clkp_b[W_B-1]));
      if (m_rst) begin
        cyc_a = 0; last_a = 0; mcnt_a = 0;
        cyc_b = 0; last_b = 0;
      end else begin
        cyc_a++;
        cyc_b++;
        if (mclk_a) mcnt_a++;
        if (inst_a) begin
          check("period_w11", 64'(cyc_a - last_a), 64'(2 * W_A + 1));
          check("mclk_len_w11", 64'(mcnt_a), 64'd2);
          last_a = cyc_a;
          mcnt_a = 0;
        end
        if (inst_b) begin
          check("period_w3", 64'(cyc_b - last_b), 64'(2 * W_B + 1));
          last_b = cyc_b;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    logic [0:W_A-1] m;
    n_checks = 0;
    n_pass   = 0;
    m_n      = 0;
    m_rst    = 1'b1;
    m_valid  = 1'b0;
    reset    = 1'b1;

    // Reset hold.
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rst_clkp", 64'(clkp_a), 64'd0);
      check("rst_mclk", 64'(mclk_a), 64'd0);
      check("rst_inst", 64'(inst_a), 64'd0);
    end

    // Rising order.
    reset = 1'b0;
    for (int k = 1; k <= W_A; k++) begin
      tick();
      for (int i = 0; i < W_A; i++) m[i] = (i < k);
      check("rise_clkp", 64'(clkp_a), 64'(m));
    end
    check("rise_mclk", 64'(mclk_a), 64'd1);

    // Plateau and falling order.
    tick();
    check("plateau_clkp", 64'(clkp_a), 64'h7FF);
    check("plateau_mclk", 64'(mclk_a), 64'd1);
    tick();
    check("fall1_clkp", 64'(clkp_a), 64'h7FE);
    check("fall1_mclk", 64'(mclk_a), 64'd0);
    run(9);
    check("edge22_clkp", 64'(clkp_a), 64'h400);
    tick();
    check("edge23_clkp", 64'(clkp_a), 64'd0);
    check("edge23_inst", 64'(inst_a), 64'd1);
    tick();
    check("edge24_inst", 64'(inst_a), 64'd0);
    check("edge24_clkp", 64'(clkp_a), 64'h400);

    // Periodicity over five cycles (monitor checks gaps and Mclk width).
    run(5 * (2 * W_A + 1) - 1);

    // Mid-cycle reset at step 7.
    run(7);
    check("pre_rst_s7", 64'(clkp_a), 64'h7F0);
    reset = 1'b1;
    tick();
    check("mid_rst_clkp", 64'(clkp_a), 64'd0);
    check("mid_rst_mclk", 64'(mclk_a), 64'd0);
    check("mid_rst_inst", 64'(inst_a), 64'd0);
    check("mid_rst_w3", 64'(clkp_b), 64'd0);
    reset = 1'b0;
    tick();
    check("restart_clkp", 64'(clkp_a), 64'h400);
    check("restart_w3", 64'(clkp_b), 64'h4);

    // Randomized run lengths with random reset pulses.
    repeat (30) begin
      run($urandom_range(1, 60));
      reset = 1'b1;
      run($urandom_range(1, 3));
      reset = 1'b0;
    end
    run(3 * (2 * W_A + 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
